parking_keypad_entry: RTL and testbench
=======================================

Name: parking_keypad_entry

Overview:
- Driver-side keypad front end for the parking gate controller.
- Collects two 2-bit key digits and presents them on password_1/password_2 with a valid flag.
- Watches the gate controller's 3-bit status to detect accept or reject, retries on reject, and locks out after repeated failures.
- Sits between the physical keypad debouncer and the parking gate controller.

Parameters:
- TIMEOUT_CYCLES, 100, idle cycles allowed per digit or per verdict wait before abandoning entry.
- MAX_RETRIES, 3, wrong-password verdicts tolerated before lockout.
- LOCKOUT_CYCLES, 200, duration of lockout state.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- car_at_gate  in  1  entrance sensor level, same signal feeding the gate controller.
- key_valid  in  1  one-cycle strobe, key_code valid.
- key_code  in  2  digit value.
- key_clear  in  1  one-cycle strobe, restart digit entry.
- gate_status  in  3  gate controller status output.
- password_1  out  2  first digit presented.
- password_2  out  2  second digit presented.
- pw_valid  out  1  high while both digits are presented.
- busy  out  1  high in any state other than IDLE.
- lockout  out  1  high in LOCKOUT.
- accepted  out  1  one-cycle pulse on GS_RIGHT verdict.
- timeout_err  out  1  one-cycle pulse on timeout abandon.
- retry_count  out  $clog2(MAX_RETRIES+1)  wrong verdicts in the current session.

Behaviour:
- Reset: all outputs 0; state IDLE; timer 0; retry_count 0. All outputs are registered.
- States: IDLE, DIGIT1, DIGIT2, PRESENT, LOCKOUT.
- IDLE:
  - Rising edge of car_at_gate (registered previous value) goes to DIGIT1 and clears the timer and retry_count.
  - key_valid and key_clear are ignored.
- DIGIT1:
  - key_valid captures key_code into password_1 and goes to DIGIT2; timer cleared.
- DIGIT2:
  - key_valid captures key_code into password_2 and goes to PRESENT.
  - pw_valid = 1 in the cycle after the strobe.
- PRESENT:
  - password_1, password_2 and pw_valid are held stable.
  - GS_RIGHT: accepted pulses, then IDLE.
  - GS_WRONG with retry_count+1 < MAX_RETRIES: retry_count increments, passwords clear to 0, pw_valid drops, then DIGIT1.
  - GS_WRONG with retry_count+1 = MAX_RETRIES: retry_count increments, then LOCKOUT.
- Timer:
  - Counts every cycle in DIGIT1, DIGIT2 and PRESENT; cleared on each state change.
  - Reaching TIMEOUT_CYCLES-1 pulses timeout_err, then IDLE with passwords cleared.
- key_clear in DIGIT1, DIGIT2 or PRESENT: passwords cleared, pw_valid 0, then DIGIT1; retry_count unchanged.
- car_at_gate falling in DIGIT1, DIGIT2 or PRESENT: immediate return to IDLE, everything cleared, no timeout_err.
- LOCKOUT:
  - lockout = 1; keys and gate_status are ignored.
  - After LOCKOUT_CYCLES the block goes to IDLE and retry_count clears.
  - A car still present needs a fresh rising edge to start again.
- Simultaneous-event priority: car_at_gate fall > key_clear > key_valid/verdict > timeout. A key arriving in the timeout cycle is accepted.
- A key_valid in PRESENT is ignored.
- Async reset mid-entry returns to IDLE immediately with outputs cleared.
- Timer width is $clog2(max(TIMEOUT_CYCLES, LOCKOUT_CYCLES)+1). The timer saturates and never wraps.

Decomposition:
- Shared package parking_pkg holds:
  - State enum.
  - Gate status constants GS_IDLE=3'b000, GS_WAIT=3'b001, GS_WRONG=3'b010, GS_RIGHT=3'b011, GS_STOP=3'b100. These are shared with the gate controller.
- One sub-module, keypad_timer: a loadable saturating down-counter with a done flag, used for both the timeout and the lockout.

Test Plan:
- Happy path:
  - Stimulus: reset released, car_at_gate 0→1, key 1, key 2, gate_status=GS_RIGHT.
  - Response: password_1=1 and password_2=2 with pw_valid=1 one cycle after the second key; accepted pulses once; busy returns to 0.
- Wrong then right:
  - Stimulus: digits 1,1, then GS_WRONG, then digits 1,2, then GS_RIGHT.
  - Response: retry_count=1 after the reject; pw_valid drops; final accepted pulse; retry_count=0 at the next session.
- Lockout:
  - Stimulus: three consecutive GS_WRONG verdicts with MAX_RETRIES=3.
  - Response: lockout=1 for exactly 200 cycles; keys ignored during lockout; then IDLE.
- Timeout:
  - Stimulus: car arrives, no keys for 100 cycles.
  - Response: timeout_err pulses once; password outputs 0; state IDLE.
- Abort and clear:
  - Stimulus: key_clear after the first digit.
  - Response: password_1 returns to 0 and entry restarts.
  - Stimulus: car_at_gate falls in PRESENT.
  - Response: IDLE with no timeout_err.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously (between clock edges) while in DIGIT2.
  - Response: all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared definitions for the parking keypad front end.
// Holds the keypad entry state enum and the gate controller status codes.
// The gate controller decodes the same status codes, so change them in both places.
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DIGIT1  = 3'd1,
        ST_DIGIT2  = 3'd2,
        ST_PRESENT = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [2:0] GS_IDLE  = 3'b000;
    localparam logic [2:0] GS_WAIT  = 3'b001;
    localparam logic [2:0] GS_WRONG = 3'b010;
    localparam logic [2:0] GS_RIGHT = 3'b011;
    localparam logic [2:0] GS_STOP  = 3'b100;

endpackage

// File: rtl/keypad_timer.sv
// Loadable saturating down-counter with a done flag.
// One instance serves both the per-digit/verdict timeout and the lockout period.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   load        - load load_value this cycle (takes priority over counting)
//   load_value  - start value; done asserts load_value cycles after the load
//   done        - count has reached zero (stays there, never wraps)
module keypad_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/parking_keypad_entry.sv
// Driver-side keypad front end for the parking gate controller.
// Collects two 2-bit digits after a car arrives, presents them to the gate
// controller, reacts to its verdict, retries on a wrong password and locks
// out after MAX_RETRIES consecutive wrong verdicts.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   car_at_gate                 - entrance sensor level
//   key_valid/key_code          - digit strobe and value from the debouncer
//   key_clear                   - restart digit entry
//   gate_status                 - gate controller status (GS_* codes)
//   password_1/password_2       - presented digits, pw_valid while both held
//   busy, lockout               - state indicators
//   accepted, timeout_err       - one-cycle event pulses
//   retry_count                 - wrong verdicts in the current session
module parking_keypad_entry
    import parking_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100,
    parameter int MAX_RETRIES    = 3,
    parameter int LOCKOUT_CYCLES = 200
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               car_at_gate,
    input  logic                               key_valid,
    input  logic [1:0]                         key_code,
    input  logic                               key_clear,
    input  logic [2:0]                         gate_status,
    output logic [1:0]                         password_1,
    output logic [1:0]                         password_2,
    output logic                               pw_valid,
    output logic                               busy,
    output logic                               lockout,
    output logic                               accepted,
    output logic                               timeout_err,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int TMAX    = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    state_t               state_q, state_d;
    logic                 car_q;
    logic [1:0]           pw1_q, pw1_d;
    logic [1:0]           pw2_q, pw2_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 pw_valid_q, busy_q, lockout_q;
    logic                 accepted_q, accepted_d;
    logic                 timeout_q, timeout_d;
    logic                 restart;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_value;
    logic                 timer_done;
    logic                 car_rise, car_fall;
    int                   retry_inc;

    assign car_rise  = car_at_gate & ~car_q;
    assign car_fall  = ~car_at_gate & car_q;
    assign retry_inc = int'(retry_q) + 1;

    always_comb begin
        state_d    = state_q;
        pw1_d      = pw1_q;
        pw2_d      = pw2_q;
        retry_d    = retry_q;
        accepted_d = 1'b0;
        timeout_d  = 1'b0;
        restart    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (car_rise) begin
                    state_d = ST_DIGIT1;
                    retry_d = '0;
                    pw1_d   = '0;
                    pw2_d   = '0;
                end
            end
            ST_DIGIT1, ST_DIGIT2, ST_PRESENT: begin
                // Event priority: car leaves > clear > key/verdict > timeout.
                if (car_fall) begin
                    state_d = ST_IDLE;
                    pw1_d   = '0;
                    pw2_d   = '0;
                    retry_d = '0;
                end else if (key_clear) begin
                    state_d = ST_DIGIT1;
                    pw1_d   = '0;
                    pw2_d   = '0;
                    restart = 1'b1;
                end else if (state_q == ST_DIGIT1 && key_valid) begin
                    state_d = ST_DIGIT2;
                    pw1_d   = key_code;
                end else if (state_q == ST_DIGIT2 && key_valid) begin
                    state_d = ST_PRESENT;
                    pw2_d   = key_code;
                end else if (state_q == ST_PRESENT && gate_status == GS_RIGHT) begin
                    state_d    = ST_IDLE;
                    accepted_d = 1'b1;
                    pw1_d      = '0;
                    pw2_d      = '0;
                end else if (state_q == ST_PRESENT && gate_status == GS_WRONG) begin
                    retry_d = RETRY_W'(retry_inc);
                    pw1_d   = '0;
                    pw2_d   = '0;
                    state_d = (retry_inc < MAX_RETRIES) ? ST_DIGIT1 : ST_LOCKOUT;
                end else if (timer_done) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    pw1_d     = '0;
                    pw2_d     = '0;
                end
            end
            ST_LOCKOUT: begin
                if (timer_done) begin
                    state_d = ST_IDLE;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The timer restarts on every state change and on a clear that stays in DIGIT1.
    // A load of N-1 makes done assert in the Nth cycle spent in the state.
    assign timer_load  = (state_d != state_q) || restart;
    assign timer_value = (state_d == ST_LOCKOUT) ? TIMER_W'(LOCKOUT_CYCLES - 1)
                                                 : TIMER_W'(TIMEOUT_CYCLES - 1);

    keypad_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            car_q      <= 1'b0;
            pw1_q      <= '0;
            pw2_q      <= '0;
            retry_q    <= '0;
            pw_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            lockout_q  <= 1'b0;
            accepted_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            car_q      <= car_at_gate;
            pw1_q      <= pw1_d;
            pw2_q      <= pw2_d;
            retry_q    <= retry_d;
            // Status flags are registered from the next state so they line up with it.
            pw_valid_q <= (state_d == ST_PRESENT);
            busy_q     <= (state_d != ST_IDLE);
            lockout_q  <= (state_d == ST_LOCKOUT);
            accepted_q <= accepted_d;
            timeout_q  <= timeout_d;
        end
    end

    assign password_1  = pw1_q;
    assign password_2  = pw2_q;
    assign pw_valid    = pw_valid_q;
    assign busy        = busy_q;
    assign lockout     = lockout_q;
    assign accepted    = accepted_q;
    assign timeout_err = timeout_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_parking_keypad_entry.sv
// Scoreboard bench for parking_keypad_entry: the stimulus process plays driver
// and gate controller, pushes expected events from a session-level model, and a
// negedge monitor pops and compares whenever the DUT shows an event.
module tb_parking_keypad_entry;
    import parking_pkg::*;

    localparam int TO_CYC  = 100;
    localparam int MAXR    = 3;
    localparam int LOCKCYC = 200;

    localparam int K_PRESENT = 0;
    localparam int K_ACCEPT  = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_LOCK    = 3;

    localparam int V_RIGHT = 0;
    localparam int V_WRONG = 1;
    localparam int V_FALL  = 2;

    typedef struct {
        int kind;
        int p1;
        int p2;
        int retry;
        int len;
        int busy;
        int aux;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       car_at_gate;
    logic       key_valid;
    logic [1:0] key_code;
    logic       key_clear;
    logic [2:0] gate_status;
    logic [1:0] password_1, password_2;
    logic       pw_valid, busy, lockout, accepted, timeout_err;
    logic [1:0] retry_count;

    ev_t sb_q[$];
    int  verdict_q[$];
    int  digit_q[$];
    bit  force_clear;
    int  n_checks = 0;
    int  n_pass   = 0;

    parking_keypad_entry #(
        .TIMEOUT_CYCLES (TO_CYC),
        .MAX_RETRIES    (MAXR),
        .LOCKOUT_CYCLES (LOCKCYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .car_at_gate (car_at_gate),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_clear   (key_clear),
        .gate_status (gate_status),
        .password_1  (password_1),
        .password_2  (password_2),
        .pw_valid    (pw_valid),
        .busy        (busy),
        .lockout     (lockout),
        .accepted    (accepted),
        .timeout_err (timeout_err),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
            $display("check %-12s act=%0d exp=%0d ok", name, act, exp);
        end else begin
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void push(input int kind, input int p1, input int p2, input int retry,
                                 input int len, input int bsy, input int aux);
        ev_t e;
        e = '{kind, p1, p2, retry, len, bsy, aux};
        sb_q.push_back(e);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic score(input ev_t a);
        ev_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL unexpected_event actual kind=%0d p1=%0d p2=%0d retry=%0d len=%0d busy=%0d aux=%0d required none",
                     a.kind, a.p1, a.p2, a.retry, a.len, a.busy, a.aux);
            return;
        end
        e = sb_q.pop_front();
        if (a == e) begin
            n_pass++;
            $display("event kind=%0d p1=%0d p2=%0d retry=%0d len=%0d busy=%0d aux=%0d ok",
                     a.kind, a.p1, a.p2, a.retry, a.len, a.busy, a.aux);
        end else begin
            $display("FAIL event actual kind=%0d p1=%0d p2=%0d retry=%0d len=%0d busy=%0d aux=%0d required kind=%0d p1=%0d p2=%0d retry=%0d len=%0d busy=%0d aux=%0d",
                     a.kind, a.p1, a.p2, a.retry, a.len, a.busy, a.aux,
                     e.kind, e.p1, e.p2, e.retry, e.len, e.busy, e.aux);
        end
    endtask

    bit pv_prev = 1'b0;
    bit lk_prev = 1'b0;
    int busy_run = 0;
    int lock_len = 0;
    int lock_retry = 0;

    always @(negedge clk) begin
        if (reset) begin
            pv_prev  = 1'b0;
            lk_prev  = 1'b0;
            busy_run = 0;
            lock_len = 0;
        end else begin
            if (pw_valid && !pv_prev)
                score('{K_PRESENT, int'(password_1), int'(password_2), int'(retry_count), 0, int'(busy), 0});
            if (accepted)
                score('{K_ACCEPT, 0, 0, int'(retry_count), 0, int'(busy), 0});
            if (timeout_err)
                score('{K_TIMEOUT, int'(password_1), int'(password_2), 0, busy_run, int'(busy), int'(pw_valid)});
            if (lockout) begin
                if (!lk_prev) lock_retry = int'(retry_count);
                lock_len++;
            end else if (lk_prev) begin
                score('{K_LOCK, 0, 0, lock_retry, lock_len, int'(busy), int'(retry_count)});
                lock_len = 0;
            end
            busy_run = busy ? busy_run + 1 : 0;
            pv_prev  = pw_valid;
            lk_prev  = lockout;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic key(input int d);
        key_valid = 1'b1;
        key_code  = 2'(d);
        tick();
        key_valid = 1'b0;
    endtask

    function automatic int next_digit();
        if (digit_q.size() != 0) return digit_q.pop_front();
        return int'($urandom_range(0, 3));
    endfunction

    function automatic int next_verdict();
        int r;
        if (verdict_q.size() != 0) return verdict_q.pop_front();
        r = int'($urandom_range(0, 9));
        if (r == 0) return V_FALL;
        if (r < 6)  return V_RIGHT;
        return V_WRONG;
    endfunction

    task automatic timeout_session();
        car_at_gate = 1'b1;
        tick();
        // No keys: the whole 100-cycle budget in DIGIT1 runs out.
        push(K_TIMEOUT, 0, 0, 0, TO_CYC, 0, 0);
        idle(TO_CYC + 10);
        car_at_gate = 1'b0;
        idle(2);
    endtask

    task automatic entry_session();
        int  retries;
        bit  done;
        int  d1, d2, v;
        car_at_gate = 1'b1;
        tick();
        retries = 0;
        done    = 1'b0;
        while (!done) begin
            idle(int'($urandom_range(0, 4)));
            d1 = next_digit();
            key(d1);
            if (force_clear || $urandom_range(0, 7) == 0) begin
                force_clear = 1'b0;
                idle(int'($urandom_range(0, 2)));
                key_clear = 1'b1;
                tick();
                key_clear = 1'b0;
                check("clear_pw1", int'(password_1), 0);
                idle(int'($urandom_range(0, 3)));
                d1 = next_digit();
                key(d1);
            end
            idle(int'($urandom_range(0, 4)));
            d2 = next_digit();
            key(d2);
            push(K_PRESENT, d1, d2, retries, 0, 1, 0);
            idle(int'($urandom_range(1, 3)));
            v = next_verdict();
            if (v == V_RIGHT) begin
                gate_status = GS_RIGHT;
                tick();
                gate_status = GS_WAIT;
                push(K_ACCEPT, 0, 0, retries, 0, 0, 0);
                done = 1'b1;
            end else if (v == V_FALL) begin
                car_at_gate = 1'b0;
                tick();
                check("fall_busy", int'(busy), 0);
                check("fall_pwvalid", int'(pw_valid), 0);
                done = 1'b1;
            end else begin
                gate_status = GS_WRONG;
                tick();
                gate_status = GS_WAIT;
                retries++;
                if (retries < MAXR) begin
                    check("wrong_pwvalid", int'(pw_valid), 0);
                    check("wrong_retry", int'(retry_count), retries);
                end else begin
                    push(K_LOCK, 0, 0, MAXR, LOCKCYC, 0, 0);
                    // Hammer keys and verdicts during the lockout; all must be ignored.
                    repeat (LOCKCYC + 5) begin
                        key_valid   = 1'($urandom_range(0, 1));
                        key_code    = 2'($urandom_range(0, 3));
                        key_clear   = ($urandom_range(0, 3) == 0);
                        gate_status = 3'($urandom_range(0, 4));
                        tick();
                    end
                    key_valid   = 1'b0;
                    key_clear   = 1'b0;
                    gate_status = GS_WAIT;
                    idle(3);
                    // Car never left, so no fresh rising edge: must stay idle.
                    check("post_lock_busy", int'(busy), 0);
                    done = 1'b1;
                end
            end
        end
        car_at_gate = 1'b0;
        idle(2);
    endtask

    initial begin
        reset       = 1'b1;
        car_at_gate = 1'b0;
        key_valid   = 1'b0;
        key_code    = 2'd0;
        key_clear   = 1'b0;
        gate_status = GS_WAIT;
        force_clear = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pw1", int'(password_1), 0);
        check("rst_pw2", int'(password_2), 0);
        check("rst_pwvalid", int'(pw_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_lockout", int'(lockout), 0);
        check("rst_accepted", int'(accepted), 0);
        check("rst_timeout", int'(timeout_err), 0);
        check("rst_retry", int'(retry_count), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Happy path: 1,2 then accepted.
        digit_q = '{1, 2};
        verdict_q = '{V_RIGHT};
        entry_session();
        // Wrong then right.
        digit_q = '{1, 1, 1, 2};
        verdict_q = '{V_WRONG, V_RIGHT};
        entry_session();
        // Three wrong verdicts: lockout.
        verdict_q = '{V_WRONG, V_WRONG, V_WRONG};
        entry_session();
        // Next session must start with retry_count back at 0.
        verdict_q = '{V_RIGHT};
        entry_session();
        timeout_session();
        // Clear after the first digit.
        force_clear = 1'b1;
        verdict_q = '{V_RIGHT};
        entry_session();
        // Car leaves while presenting.
        verdict_q = '{V_FALL};
        entry_session();

        for (int s = 0; s < 25; s++) begin
            if ($urandom_range(0, 9) == 0) timeout_session();
            else entry_session();
        end

        // Asynchronous reset while in DIGIT2.
        car_at_gate = 1'b1;
        tick();
        key(2);
        check("pre_rst_pw1", int'(password_1), 2);
        #3;
        reset = 1'b1;
        #1;
        check("arst_pw1", int'(password_1), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_all", int'({password_1, password_2, pw_valid, busy, lockout,
                                accepted, timeout_err, retry_count}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        car_at_gate = 1'b0;
        idle(3);

        for (int i = 0; i < 1000 && sb_q.size() != 0; i++) @(negedge clk);
        check("sb_drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
